// File: rtl/dmem_responder.sv
// dmem_responder: slave end of the processor's dmem port.
// Serves word-addressed loads/stores from an internal RAM and decodes an
// MMIO window at 0xFFFF_xxxx holding an output FIFO, a STATUS register and
// an optional free-running cycle counter (enabled by DMEM_CYCLE_COUNTER_EN).
//
// Ports:
//   clock         master clock
//   reset         synchronous, active-low reset
//   address_dmem  word address from the processor
//   data          store data
//   wren          store enable
//   q_dmem        load data, registered on the falling edge
//   out_data      FIFO head word
//   out_valid     FIFO non-empty
//   out_ready     consumer accepts the head word this cycle
module dmem_responder #(
    parameter int unsigned ADDR_BITS  = 12,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam int unsigned RAM_WORDS = 1 << ADDR_BITS;

    localparam logic [15:0] OFF_FIFO   = 16'h0000;
    localparam logic [15:0] OFF_STATUS = 16'h0001;
    localparam logic [15:0] OFF_CYCLES = 16'h0002;

    logic [31:0]      r_ram  [RAM_WORDS];
    logic [31:0]      r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic [31:0]      r_q;

    logic                 w_mmio;
    logic [15:0]          w_offset;
    logic [ADDR_BITS-1:0] w_ram_idx;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_push;
    logic                 w_push_ok;
    logic                 w_pop;
    logic                 w_status_wr;
    logic [31:0]          w_status;
    logic [31:0]          w_cycles;
    logic [31:0]          w_rd_data;

    // Address decode
    assign w_mmio    = (address_dmem[31:16] == 16'hFFFF);
    assign w_offset  = address_dmem[15:0];
    assign w_ram_idx = address_dmem[ADDR_BITS-1:0];

    // FIFO handshake; a push into a full FIFO only lands if a pop frees a slot
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_push      = wren && w_mmio && (w_offset == OFF_FIFO);
    assign w_pop       = out_valid && out_ready;
    assign w_push_ok   = w_push && (!w_full || w_pop);
    assign w_status_wr = wren && w_mmio && (w_offset == OFF_STATUS);

    assign w_status  = {16'b0, 8'(r_count), 5'b0, r_overflow, w_full, w_empty};
    assign out_valid = !w_empty;
    assign out_data  = r_fifo[r_rptr];
    assign q_dmem    = r_q;

    // FIFO storage, pointers, occupancy and sticky overflow
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_fifo[i] <= '0;
            end
        end else begin
            if (w_push_ok) begin
                r_fifo[r_wptr] <= data;
                r_wptr         <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push_ok && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (w_push && !w_push_ok) begin
                r_overflow <= 1'b1;
            end else if (w_status_wr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // RAM contents survive reset; stores in a reset cycle are discarded
    always_ff @(posedge clock) begin
        if (reset && wren && !w_mmio) begin
            r_ram[w_ram_idx] <= data;
        end
    end

`ifdef DMEM_CYCLE_COUNTER_EN
    logic [31:0] r_cycles;

    // Free-running cycle counter, wraps naturally
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cycles <= '0;
        end else begin
            r_cycles <= r_cycles + 32'd1;
        end
    end

    assign w_cycles = r_cycles;
`else
    assign w_cycles = '0;
`endif

    // Read mux
    always_comb begin
        w_rd_data = '0;
        if (w_mmio) begin
            case (w_offset)
                OFF_STATUS: w_rd_data = w_status;
                OFF_CYCLES: w_rd_data = w_cycles;
                default:    w_rd_data = '0;
            endcase
        end else begin
            w_rd_data = r_ram[w_ram_idx];
        end
    end

    // Load data captured mid-cycle, before the store at the next rising edge
    always_ff @(negedge clock) begin
        if (!reset) begin
            r_q <= '0;
        end else begin
            r_q <= w_rd_data;
        end
    end

endmodule
